// File: rtl/rs_gf_pkg.sv
// GF(2^M) helpers shared by the RS syndrome stream.
//   GF_M_DEF / GF_POLY_DEF : default field, GF(16) with x^4+x+1
//   GF_MAX_M               : widest field the helpers support
//   gf_xtime               : multiply by alpha (x) with reduction
//   gf_alpha_pow           : alpha^e, exponent taken mod 2^M-1
//   gf_mul_const           : a * c by shift-and-add; with c constant this
//                            collapses to a pure XOR network
//   clog2_f                : ceiling log2
package rs_gf_pkg;

  localparam int unsigned GF_MAX_M = 16;
  localparam int unsigned GF_M_DEF = 4;
  localparam logic [GF_M_DEF:0] GF_POLY_DEF = 5'b10011;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [GF_MAX_M-1:0] gf_xtime(
    input logic [GF_MAX_M-1:0] x,
    input int unsigned         m,
    input logic [GF_MAX_M:0]   poly
  );
    logic [GF_MAX_M:0] t;
    t = {x, 1'b0};
    if (t[m]) t = t ^ poly;
    return t[GF_MAX_M-1:0];
  endfunction

  function automatic int unsigned gf_alpha_pow(
    input int unsigned       e,
    input int unsigned       m,
    input logic [GF_MAX_M:0] poly
  );
    logic [GF_MAX_M-1:0] x;
    int unsigned order;
    order = (32'd1 << m) - 32'd1;
    x = '0;
    x[0] = 1'b1;
    for (int unsigned i = 0; i < (e % order); i++) begin
      x = gf_xtime(x, m, poly);
    end
    return 32'(x);
  endfunction

  function automatic logic [GF_MAX_M-1:0] gf_mul_const(
    input logic [GF_MAX_M-1:0] a,
    input logic [GF_MAX_M-1:0] c,
    input int unsigned         m,
    input logic [GF_MAX_M:0]   poly
  );
    logic [GF_MAX_M-1:0] r;
    r = '0;
    // Horner over the bits of c, MSB first.
    for (int unsigned i = 0; i < m; i++) begin
      r = gf_xtime(r, m, poly);
      if (c[m - 1 - i]) r = r ^ a;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_stream_if.sv
// Symbol-in / syndrome-out bundle of rs_syndrome_stream.
//   IN_VALID, IN_SOF, IN_SERIAL : symbol stream into the calculator
//   SYN_VALID, S_OUT, SYM_CNT   : registered results out of it
//   ERR_DET                     : present only with RS_SYN_ERR_FLAG_EN
// master = symbol source / syndrome sink, slave = the calculator.
interface rs_syndrome_stream_if
  import rs_gf_pkg::*;
#(
  parameter int unsigned M    = GF_M_DEF,
  parameter int unsigned N    = 15,
  parameter int unsigned NSYN = 4
) ();

  localparam int unsigned CW = clog2_f(N + 1);

  logic              IN_VALID;
  logic              IN_SOF;
  logic [M-1:0]      IN_SERIAL;
  logic              SYN_VALID;
  logic [NSYN*M-1:0] S_OUT;
  logic [CW-1:0]     SYM_CNT;
`ifdef RS_SYN_ERR_FLAG_EN
  logic              ERR_DET;
`endif

  modport master (
    output IN_VALID, IN_SOF, IN_SERIAL,
`ifdef RS_SYN_ERR_FLAG_EN
    input  ERR_DET,
`endif
    input  SYN_VALID, S_OUT, SYM_CNT
  );

  modport slave (
    input  IN_VALID, IN_SOF, IN_SERIAL,
`ifdef RS_SYN_ERR_FLAG_EN
    output ERR_DET,
`endif
    output SYN_VALID, S_OUT, SYM_CNT
  );

endinterface

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: acc <= acc*ROOT ^ sym on each enabled symbol,
// or acc <= sym on the first symbol of a frame.
//   clk, rst  : clock, async active-high reset
//   en        : symbol accepted this cycle
//   first     : symbol starts a frame (old contents discarded)
//   sym       : received symbol
//   acc_next  : value acc takes at this edge if en (used for the
//               frame-completing snapshot)
module rs_syn_cell
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M_DEF,
  parameter logic [M:0]  PRIM_POLY = GF_POLY_DEF,
  parameter int unsigned ROOT      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         first,
  input  logic [M-1:0] sym,
  output logic [M-1:0] acc_next
);

  localparam logic [GF_MAX_M:0]   POLY_EXT = (GF_MAX_M + 1)'(PRIM_POLY);
  localparam logic [GF_MAX_M-1:0] ROOT_V   = ROOT[GF_MAX_M-1:0];

  logic [M-1:0]        acc;
  logic [GF_MAX_M-1:0] acc_ext;
  logic [GF_MAX_M-1:0] prod_ext;
  logic                unused_hi;

  always_comb begin
    acc_ext         = '0;
    acc_ext[M-1:0]  = acc;
    prod_ext        = gf_mul_const(acc_ext, ROOT_V, M, POLY_EXT);
    acc_next        = first ? sym : (prod_ext[M-1:0] ^ sym);
  end

  // Product bits above M are always zero after reduction.
  assign unused_hi = ^prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming RS(N,K) syndrome calculator over GF(2^M).
//   CLK, RESET : clock (rising edge), async active-high reset
//   bus        : rs_syndrome_stream_if slave modport
//     IN_VALID/IN_SOF/IN_SERIAL : symbols, highest degree first, gaps allowed
//     SYN_VALID : one-cycle pulse, S_OUT holds a completed frame's syndromes
//     S_OUT     : S_j at [j*M +: M], S_j = r(alpha^(FCR+j))
//     SYM_CNT   : symbols accepted in the current frame (0..N-1)
//     ERR_DET   : OR of the new syndromes; only with RS_SYN_ERR_FLAG_EN
// Optional feature macro: RS_SYN_ERR_FLAG_EN.
module rs_syndrome_stream
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M_DEF,
  parameter logic [M:0]  PRIM_POLY = GF_POLY_DEF,
  parameter int unsigned N         = 15,
  parameter int unsigned NSYN      = 4,
  parameter int unsigned FCR       = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  rs_syndrome_stream_if.slave  bus
);

  localparam int unsigned        CW       = clog2_f(N + 1);
  localparam logic [GF_MAX_M:0]  POLY_EXT = (GF_MAX_M + 1)'(PRIM_POLY);

  logic              first;
  logic              done;
  logic [CW-1:0]     cnt_inc;
  logic [NSYN*M-1:0] s_next;

  // A zero count also starts a frame: covers reset, completion and
  // back-to-back frames that arrive without IN_SOF.
  always_comb begin
    first   = bus.IN_SOF || (bus.SYM_CNT == '0);
    cnt_inc = first ? CW'(1) : (bus.SYM_CNT + CW'(1));
    done    = bus.IN_VALID && (cnt_inc == CW'(N));
  end

  for (genvar j = 0; j < NSYN; j++) begin : g_cell
    rs_syn_cell #(
      .M         (M),
      .PRIM_POLY (PRIM_POLY),
      .ROOT      (gf_alpha_pow(FCR + 32'(j), M, POLY_EXT))
    ) u_cell (
      .clk      (CLK),
      .rst      (RESET),
      .en       (bus.IN_VALID),
      .first    (first),
      .sym      (bus.IN_SERIAL),
      .acc_next (s_next[j*M +: M])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.SYN_VALID <= 1'b0;
      bus.S_OUT     <= '0;
      bus.SYM_CNT   <= '0;
`ifdef RS_SYN_ERR_FLAG_EN
      bus.ERR_DET   <= 1'b0;
`endif
    end else begin
      bus.SYN_VALID <= done;
      if (bus.IN_VALID) begin
        bus.SYM_CNT <= done ? '0 : cnt_inc;
      end
      if (done) begin
        bus.S_OUT   <= s_next;
`ifdef RS_SYN_ERR_FLAG_EN
        bus.ERR_DET <= |s_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed bench for rs_syndrome_stream at GF(16), N=15, NSYN=4, FCR=1.
// Frames are 60-bit vectors, degree d coefficient at [d*4 +: 4].
module tb_rs_syndrome_stream;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  rs_syndrome_stream_if #(.M(4), .N(15), .NSYN(4)) bus ();

  rs_syndrome_stream #(
    .M         (4),
    .PRIM_POLY (5'b10011),
    .N         (15),
    .NSYN      (4),
    .FCR       (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] s_q [$];
  int          c_q [$];
  int          exp_cyc_q [$];
`ifdef RS_SYN_ERR_FLAG_EN
  logic        e_q [$];
`endif

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.SYN_VALID) begin
      s_q.push_back(bus.S_OUT);
      c_q.push_back(cyc);
`ifdef RS_SYN_ERR_FLAG_EN
      e_q.push_back(bus.ERR_DET);
`endif
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.IN_VALID  = 1'b0;
      bus.IN_SOF    = 1'b0;
      bus.IN_SERIAL = 4'h0;
    end
  endtask

  task automatic send_frame(input logic [59:0] fr, input int nsym, input bit use_sof, input bit gaps);
    for (int i = 0; i < nsym; i++) begin
      @(negedge CLK);
      bus.IN_VALID  = 1'b1;
      bus.IN_SOF    = use_sof && (i == 0);
      bus.IN_SERIAL = fr[(14 - i)*4 +: 4];
      if (i == 14) exp_cyc_q.push_back(cyc);
      if (gaps && (i % 3 == 1)) begin
        // Idle cycles with junk data and stray SOF must be ignored.
        for (int g = 0; g <= i % 4; g++) begin
          @(negedge CLK);
          bus.IN_VALID  = 1'b0;
          bus.IN_SOF    = g[0];
          bus.IN_SERIAL = 4'hF;
        end
      end
    end
  endtask

  task automatic expect_frames(input string tag, input int n, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    check({tag, "_npulse"}, 64'(s_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (s_q.size() == 0 || exp_cyc_q.size() == 0) begin
        check({tag, "_pulse_present"}, 64'd0, 64'd1);
      end else begin
        check({tag, "_s_out"}, 64'(s_q.pop_front()), 64'(ex[k]));
        check({tag, "_latency"}, 64'(c_q.pop_front()), 64'(exp_cyc_q.pop_front() + 1));
`ifdef RS_SYN_ERR_FLAG_EN
        check({tag, "_err_det"}, 64'(e_q.pop_front()), 64'(ex[k] != 16'h0));
`endif
      end
    end
    s_q.delete();
    c_q.delete();
    exp_cyc_q.delete();
`ifdef RS_SYN_ERR_FLAG_EN
    e_q.delete();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET         = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_SOF    = 1'b0;
    bus.IN_SERIAL = 4'h0;
    repeat (2) @(negedge CLK);
    check("rst_syn_valid", 64'(bus.SYN_VALID), 64'd0);
    check("rst_s_out", 64'(bus.S_OUT), 64'd0);
    check("rst_sym_cnt", 64'(bus.SYM_CNT), 64'd0);
    RESET = 1'b0;
    idle(1);

    send_frame(60'h0, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("zero", 1, 16'h0000, 16'h0, 16'h0);

    send_frame(60'h1, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("deg0", 1, 16'h1111, 16'h0, 16'h0);

    send_frame(60'h10, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("deg1", 1, 16'h3842, 16'h0, 16'h0);

    send_frame(60'h100000000000000, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("deg14", 1, 16'hEFD9, 16'h0, 16'h0);

    // 5*x + 6: S = {9,8,1,12}
    send_frame(60'h56, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("mixed", 1, 16'h981C, 16'h0, 16'h0);

    send_frame(60'h100000000000000, 15, 1'b1, 1'b1);
    idle(2);
    expect_frames("gaps", 1, 16'hEFD9, 16'h0, 16'h0);

    // Third frame has no SOF: a zero count starts it.
    send_frame(60'h10, 15, 1'b1, 1'b0);
    send_frame(60'h100000000000000, 15, 1'b1, 1'b0);
    send_frame(60'h1, 15, 1'b0, 1'b0);
    idle(2);
    expect_frames("b2b", 3, 16'h3842, 16'hEFD9, 16'h1111);
    idle(5);
    check("hold_s_out", 64'(bus.S_OUT), 64'h1111);

    send_frame(60'h100000000000000, 5, 1'b1, 1'b0);
    idle(1);
    check("pre_rst_cnt", 64'(bus.SYM_CNT), 64'd5);
    #1 RESET = 1'b1;
    #1;
    check("midrst_s_out", 64'(bus.S_OUT), 64'd0);
    check("midrst_sym_cnt", 64'(bus.SYM_CNT), 64'd0);
    check("midrst_syn_valid", 64'(bus.SYN_VALID), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    send_frame(60'h100000000000000, 15, 1'b0, 1'b0);
    idle(2);
    expect_frames("post_rst", 1, 16'hEFD9, 16'h0, 16'h0);

    send_frame(60'h100000000000000, 7, 1'b1, 1'b0);
    idle(1);
    check("abort_cnt", 64'(bus.SYM_CNT), 64'd7);
    send_frame(60'h0, 15, 1'b1, 1'b0);
    idle(2);
    expect_frames("abort", 1, 16'h0000, 16'h0, 16'h0);
    check("end_sym_cnt", 64'(bus.SYM_CNT), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
